pulse_sum_accum: RTL and testbench

- Parametrised, handshaked successor to the three-input 4-bit pulse adder in the health-monitor datapath.
- Captures NUM_CH pulse-count channels in one transfer, then adds them serially, one channel per clock.
- Presents the total with overflow indication, in saturating or wrapping mode.
- Sits between the per-sensor pulse counters and the display/alarm logic.

---
 rtl/pulse_sum_pkg.sv | 22 ++
 rtl/pulse_avg4.sv | 70 +++++++
 rtl/pulse_sum_accum.sv | 147 ++++++++++++++
 tb/tb_pulse_sum_accum.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_sum_pkg
// Purpose  : Shared types and constants for the pulse-count accumulator.
//            pulse_sum_state_t - accumulator control states
//            AVG_DEPTH         - number of results in the averaging window
//            AVG_SHIFT         - log2(AVG_DEPTH), the divide-by-window shift
// Revision : 1.0 - initial release
// ============================================================================
package pulse_sum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } pulse_sum_state_t;

    localparam int AVG_DEPTH = 4;
    localparam int AVG_SHIFT = 2;

endpackage
`default_nettype wire

// File: rtl/pulse_avg4.sv
`default_nettype none
// ============================================================================
// Module   : pulse_avg4
// Purpose  : Running average of the last AVG_DEPTH accepted results.
// Ports    : clk       - clock, rising edge
//            rst_n     - synchronous active-low reset
//            push      - a new result is accepted this cycle
//            din       - the accepted result
//            avg       - registered window sum >> AVG_SHIFT
//            avg_valid - window has been filled once; sticky until reset
// Revision : 1.0 - initial release
// ============================================================================
module pulse_avg4
    import pulse_sum_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic [W-1:0] avg,
    output logic         avg_valid
);

    localparam int TOT_W = W + AVG_SHIFT;
    localparam logic [AVG_SHIFT-1:0] c_cnt_full = AVG_SHIFT'(AVG_DEPTH - 1);

    // Only the previous AVG_DEPTH-1 results are stored; the incoming value
    // completes the window, and the oldest entry simply drops out.
    logic [W-1:0]         r_win [AVG_DEPTH-1];
    logic [AVG_SHIFT-1:0] r_cnt;
    logic [W-1:0]         r_avg;
    logic                 r_avg_valid;
    logic [TOT_W-1:0]     w_total;

    always_comb begin
        w_total = TOT_W'(din);
        for (int i = 0; i < AVG_DEPTH - 1; i++) begin
            w_total = w_total + TOT_W'(r_win[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < AVG_DEPTH - 1; i++) begin
                r_win[i] <= '0;
            end
            r_cnt       <= '0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
        end else if (push) begin
            r_win[0] <= din;
            for (int i = 1; i < AVG_DEPTH - 1; i++) begin
                r_win[i] <= r_win[i-1];
            end
            r_avg <= W'(w_total >> AVG_SHIFT);
            if (r_cnt == c_cnt_full) begin
                r_avg_valid <= 1'b1;
            end else begin
                r_cnt <= r_cnt + AVG_SHIFT'(1);
            end
        end
    end

    assign avg       = r_avg;
    assign avg_valid = r_avg_valid;

endmodule
`default_nettype wire

// File: rtl/pulse_sum_accum.sv
`default_nettype none
// ============================================================================
// Module   : pulse_sum_accum
// Purpose  : Captures NUM_CH pulse counts in one handshake, adds them one
//            channel per clock, and presents a saturated or wrapped total
//            with an overflow flag.
// Ports    : clk, rst_n          - clock / synchronous active-low reset
//            in_valid, in_ready  - input vector handshake
//            in_data             - channel k at [k*DATA_W +: DATA_W]
//            out_valid,out_ready - result handshake
//            sum, overflow       - result, held until accepted
//            busy                - accumulating or holding a result
//            avg, avg_valid      - (PULSE_SUM_AVG_EN only) 4-result average
// Config   : define PULSE_SUM_AVG_EN to add the averaging window outputs.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_sum_accum
    import pulse_sum_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int DATA_W   = 4,
    parameter int OUT_W    = 4,
    parameter int SATURATE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         sum,
    output logic                     overflow,
    output logic                     busy
`ifdef PULSE_SUM_AVG_EN
    ,
    output logic [OUT_W-1:0]         avg,
    output logic                     avg_valid
`endif
);

    // NUM_CH*(2^DATA_W-1) always fits in DATA_W+clog2(NUM_CH) bits.
    localparam int SUM_W = (NUM_CH > 1) ? DATA_W + $clog2(NUM_CH) : DATA_W;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int EXT_W = (OUT_W > SUM_W) ? OUT_W : SUM_W;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_CH - 1);

    pulse_sum_state_t          r_state;
    logic [NUM_CH*DATA_W-1:0]  r_chan;
    logic [SUM_W-1:0]          r_acc;
    logic [IDX_W-1:0]          r_idx;
    logic [OUT_W-1:0]          r_sum;
    logic                      r_overflow;
    logic                      r_out_valid;
    logic                      r_busy;

    logic [DATA_W-1:0]         w_chan;
    logic [SUM_W-1:0]          w_acc_next;
    logic [EXT_W-1:0]          w_acc_ext;
    logic                      w_ovf;
    logic [OUT_W-1:0]          w_sum;

    assign w_chan     = r_chan[int'(r_idx) * DATA_W +: DATA_W];
    assign w_acc_next = r_acc + SUM_W'(w_chan);
    assign w_acc_ext  = EXT_W'(w_acc_next);

    // Overflow is any set bit above the output width; when the output is
    // at least as wide as the accumulator it can never happen.
    generate
        if (EXT_W > OUT_W) begin : g_ovf_chk
            assign w_ovf = |w_acc_ext[EXT_W-1:OUT_W];
        end else begin : g_ovf_none
            assign w_ovf = 1'b0;
        end
    endgenerate

    assign w_sum = ((SATURATE != 0) && w_ovf) ? {OUT_W{1'b1}}
                                              : w_acc_ext[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_chan      <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_chan  <= in_data;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + IDX_W'(1);
                    // The edge that adds the final channel also registers
                    // the result, so out_valid rises NUM_CH edges after capture.
                    if (r_idx == c_last_idx) begin
                        r_sum       <= w_sum;
                        r_overflow  <= w_ovf;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign overflow  = r_overflow;
    assign busy      = r_busy;

`ifdef PULSE_SUM_AVG_EN
    pulse_avg4 #(
        .W (OUT_W)
    ) u_avg (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (r_out_valid && out_ready),
        .din       (r_sum),
        .avg       (avg),
        .avg_valid (avg_valid)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_pulse_sum_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_sum_accum
// Purpose  : Self-checking bench for pulse_sum_accum across four
//            configurations: legacy saturating, wrapping, 8x8->11 and
//            single-channel. Expected results are queued at issue time and
//            checked by an independent output monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_sum_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv   [4];
    logic        ordy [4];
    logic [63:0] din  [4];
    logic        ir   [4];
    logic        ov   [4];
    logic        of   [4];
    logic        bz   [4];
    logic [10:0] so   [4];
    logic [3:0]  s0, s1, s3;
    logic [10:0] s2;

    assign so[0] = 11'(s0);
    assign so[1] = 11'(s1);
    assign so[2] = s2;
    assign so[3] = 11'(s3);

`ifdef PULSE_SUM_AVG_EN
    logic [3:0]  avg0, avg1, avg3;
    logic [10:0] avg2;
    logic        avgv0, avgv1, avgv2, avgv3;
`endif

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    pulse_sum_accum #(.NUM_CH(3), .DATA_W(4), .OUT_W(4), .SATURATE(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(din[0][11:0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .sum(s0), .overflow(of[0]), .busy(bz[0])
`ifdef PULSE_SUM_AVG_EN
        , .avg(avg0), .avg_valid(avgv0)
`endif
    );

    pulse_sum_accum #(.NUM_CH(3), .DATA_W(4), .OUT_W(4), .SATURATE(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(din[1][11:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .sum(s1), .overflow(of[1]), .busy(bz[1])
`ifdef PULSE_SUM_AVG_EN
        , .avg(avg1), .avg_valid(avgv1)
`endif
    );

    pulse_sum_accum #(.NUM_CH(8), .DATA_W(8), .OUT_W(11), .SATURATE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(din[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .sum(s2), .overflow(of[2]), .busy(bz[2])
`ifdef PULSE_SUM_AVG_EN
        , .avg(avg2), .avg_valid(avgv2)
`endif
    );

    pulse_sum_accum #(.NUM_CH(1), .DATA_W(4), .OUT_W(4), .SATURATE(1)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .in_data(din[3][3:0]), .out_valid(ov[3]), .out_ready(ordy[3]),
        .sum(s3), .overflow(of[3]), .busy(bz[3])
`ifdef PULSE_SUM_AVG_EN
        , .avg(avg3), .avg_valid(avgv3)
`endif
    );

    typedef struct {
        int inst;
        int sum;
        int ovf;
        int start;
        int lat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one vector to instance k; optionally queue its expected result
    // and optionally wait until the block is ready again.
    task automatic send(input int k, input logic [63:0] data, input int es,
                        input int eo, input int lat, input bit expect_res,
                        input bit wait_done);
        int t;
        t = 0;
        while (!ir[k] && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!ir[k]) begin
            n_cmp++; n_bad++;
            $display("FAIL send_ready%0d: in_ready stuck at 0, expected 1", k);
            return;
        end
        din[k] = data;
        iv[k]  = 1'b1;
        @(posedge clk); #1;
        iv[k]  = 1'b0;
        if (expect_res) q.push_back('{k, es, eo, cyc, lat});
        chk($sformatf("busy_after_capture%0d", k), int'(bz[k]), 1);
        if (wait_done) begin
            t = 0;
            while (!ir[k] && t < 50) begin
                @(posedge clk); #1; t++;
            end
            if (!ir[k]) begin
                n_cmp++; n_bad++;
                $display("FAIL done_timeout%0d: in_ready stuck at 0, expected 1", k);
            end
        end
    endtask

    // Output monitor: records when out_valid rises, and compares each
    // accepted result against the oldest outstanding expectation.
    int rise [4];
    bit seen [4];
    always @(negedge clk) begin : mon
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (!ov[k]) seen[k] = 1'b0;
            else if (!seen[k]) begin
                seen[k] = 1'b1;
                rise[k] = cyc;
            end
            if (rst_n && ov[k] && ordy[k]) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_result%0d: got sum=%0d, expected no result", k, so[k]);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("result_inst%0d", k), k, e.inst);
                    chk($sformatf("sum%0d", k), int'(so[k]), e.sum);
                    chk($sformatf("overflow%0d", k), int'(of[k]), e.ovf);
                    chk($sformatf("latency%0d", k), rise[k] - e.start, e.lat);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1; din[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_in_ready%0d", k),  int'(ir[k]), 1);
            chk($sformatf("rst_out_valid%0d", k), int'(ov[k]), 0);
            chk($sformatf("rst_sum%0d", k),       int'(so[k]), 0);
            chk($sformatf("rst_overflow%0d", k),  int'(of[k]), 0);
            chk($sformatf("rst_busy%0d", k),      int'(bz[k]), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Legacy 3x4-bit saturating
        send(0, 64'h555, 15, 0, 3, 1, 1);
        send(0, 64'h556, 15, 1, 3, 1, 1);
        send(0, 64'h000,  0, 0, 3, 1, 1);
        send(0, 64'hFFF, 15, 1, 3, 1, 1);
        // Wrapping
        send(1, 64'h556,  0, 1, 3, 1, 1);
        send(1, 64'hFFF, 13, 1, 3, 1, 1);
        send(1, 64'h843, 15, 0, 3, 1, 1);
        // 8 channels x 8 bits into 11 bits
        send(2, 64'hFFFF_FFFF_FFFF_FFFF, 2040, 0, 8, 1, 1);
        send(2, 64'h0807_0605_0403_0201,   36, 0, 8, 1, 1);
        // Single channel
        send(3, 64'h9,  9, 0, 1, 1, 1);
        send(3, 64'hF, 15, 0, 1, 1, 1);

        // Backpressure: hold the result, poke in_valid with other data
        ordy[0] = 1'b0;
        send(0, 64'h555, 15, 0, 3, 1, 0);
        t = 0;
        while (!ov[0] && t < 50) begin
            @(posedge clk); #1; t++;
        end
        iv[0]  = 1'b1;
        din[0] = 64'h123;
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", int'(ov[0]), 1);
            chk("bp_sum",       int'(so[0]), 15);
            chk("bp_overflow",  int'(of[0]), 0);
            chk("bp_in_ready",  int'(ir[0]), 0);
        end
        @(posedge clk); #1;
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        chk("bp_in_ready_before_accept", int'(ir[0]), 0);
        @(posedge clk); #1;
        chk("bp_in_ready_after_accept", int'(ir[0]), 1);
        chk("bp_out_valid_after_accept", int'(ov[0]), 0);
        repeat (6) @(posedge clk);
        #1;

        // Reset one edge into accumulation: nothing may come out
        send(0, 64'h321, 0, 0, 3, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", int'(ov[0]), 0);
        chk("mid_rst_in_ready",  int'(ir[0]), 1);
        chk("mid_rst_sum",       int'(so[0]), 0);
        chk("mid_rst_busy",      int'(bz[0]), 0);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;

`ifdef PULSE_SUM_AVG_EN
        send(0, 64'h004,  4, 0, 3, 1, 1);
        send(0, 64'h008,  8, 0, 3, 1, 1);
        send(0, 64'h00C, 12, 0, 3, 1, 1);
        chk("avg_valid_after3", int'(avgv0), 0);
        send(0, 64'h000,  0, 0, 3, 1, 1);
        chk("avg_valid_after4", int'(avgv0), 1);
        chk("avg_after4",       int'(avg0), 6);
        send(0, 64'h004,  4, 0, 3, 1, 1);
        chk("avg_valid_after5", int'(avgv0), 1);
        chk("avg_after5",       int'(avg0), 6);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("outstanding_results", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
